mul_tree_issue: RTL



---
 rtl/mul_tree_issue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mul_tree_issue.sv
// Issue/retire wrapper around an external 32x32 combinational multiplier tree, with an output result FIFO.
// Optional `MUL_TREE_OVF_EN adds out_ovf, a per-result flag set when the product does not fit in 32 bits.
module mul_tree_issue #(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [WIDTH-1:0]   tree_a,
    output logic [WIDTH-1:0]   tree_b,
    input  logic [2*WIDTH-1:0] tree_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag,
`ifdef MUL_TREE_OVF_EN
    output logic               out_ovf,
`endif
    output logic               busy
);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (WIDTH != 32) begin : g_bad_width
        $error("mul_tree_issue: WIDTH must be 32 to match the multiplier tree");
    end
    if (OUT_DEPTH != 2 && OUT_DEPTH != 4) begin : g_bad_depth
        $error("mul_tree_issue: OUT_DEPTH must be 2 or 4");
    end

    logic               s1_valid_q, s1_valid_d;
    logic               s1_neg_q, s1_neg_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
    logic [WIDTH-1:0]   tree_a_q, tree_a_d;
    logic [WIDTH-1:0]   tree_b_q, tree_b_d;
    logic [2*WIDTH-1:0] prod_q [OUT_DEPTH];
    logic [2*WIDTH-1:0] prod_d [OUT_DEPTH];
    logic [TAG_W-1:0]   tag_q [OUT_DEPTH];
    logic [TAG_W-1:0]   tag_d [OUT_DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               pop, push, accept;
    logic [2*WIDTH-1:0] prod_fin;
`ifdef MUL_TREE_OVF_EN
    logic               s1_sgn_q, s1_sgn_d;
    logic               ovf_q [OUT_DEPTH];
    logic               ovf_d [OUT_DEPTH];
    logic               ovf_fin;
`endif

    always_comb begin
        pop      = (count_q != '0) && out_ready;
        // A full FIFO still takes the retiring result when its head leaves on the same edge.
        push     = s1_valid_q && ((count_q < DEPTH_C) || pop);
        in_ready = !s1_valid_q || push;
        accept   = in_valid && in_ready;
        prod_fin = s1_neg_q ? (~tree_p + (2*WIDTH)'(1)) : tree_p;

        s1_valid_d = s1_valid_q;
        s1_neg_d   = s1_neg_q;
        s1_tag_d   = s1_tag_q;
        tree_a_d   = tree_a_q;
        tree_b_d   = tree_b_q;
        if (push) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_tag_d   = in_tag;
            tree_a_d   = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
            tree_b_d   = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
        end

        prod_d   = prod_q;
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            prod_d[wr_ptr_q] = prod_fin;
            tag_d[wr_ptr_q]  = s1_tag_q;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

`ifdef MUL_TREE_OVF_EN
    always_comb begin
        s1_sgn_d = accept ? in_signed : s1_sgn_q;
        // Signed results fit when bits [63:31] are all copies of the sign bit.
        ovf_fin  = s1_sgn_q ? !((&prod_fin[2*WIDTH-1:WIDTH-1]) || !(|prod_fin[2*WIDTH-1:WIDTH-1]))
                            : (|prod_fin[2*WIDTH-1:WIDTH]);
        ovf_d    = ovf_q;
        if (push) begin
            ovf_d[wr_ptr_q] = ovf_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sgn_q <= 1'b0;
            ovf_q    <= '{default: 1'b0};
        end else begin
            s1_sgn_q <= s1_sgn_d;
            ovf_q    <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_neg_q   <= 1'b0;
            s1_tag_q   <= '0;
            tree_a_q   <= '0;
            tree_b_q   <= '0;
            prod_q     <= '{default: '0};
            tag_q      <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_neg_q   <= s1_neg_d;
            s1_tag_q   <= s1_tag_d;
            tree_a_q   <= tree_a_d;
            tree_b_q   <= tree_b_d;
            prod_q     <= prod_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        tree_a    = tree_a_q;
        tree_b    = tree_b_q;
        out_valid = (count_q != '0);
        out_prod  = out_valid ? prod_q[rd_ptr_q] : '0;
        out_tag   = out_valid ? tag_q[rd_ptr_q] : '0;
        busy      = s1_valid_q || out_valid;
`ifdef MUL_TREE_OVF_EN
        out_ovf   = out_valid ? ovf_q[rd_ptr_q] : 1'b0;
`endif
    end

endmodule
